seven_seg_scan_mux: RTL
=======================

// Module: seven_seg_scan_mux
// PURPOSE
//  Downstream of the hex-to-seven-segment decode stage. Takes the two 8-bit digit patterns
//  (SevenSegDig1 = high nibble, SevenSegDig2 = low nibble) and time-multiplexes them onto
//  one shared segment bus with per-digit enables for a common-segment 2-digit display.
//  Patterns are double-buffered and only change at frame boundaries, so the display never tears.
// PARAMETERS
//  DWELL_CYCLES  4000  clocks each digit is lit per frame (>=2)
//  BLANK_CYCLES  16    anti-ghosting clocks with all enables off before each digit (>=0; 0 = no blank state)
// PORTS
//  Clock     in   1  system clock, all logic on rising edge
//  Reset     in   1  synchronous, active-high
//  Dig1      in   8  pattern for digit 1, bit0=a..bit6=g, bit7=dp, active-high
//  Dig2      in   8  pattern for digit 2, same encoding
//  Load      in   1  1-cycle strobe: capture Dig1/Dig2 into pending buffer
//  Segments  out  8  shared segment bus, active-high
//  DigitEn   out  2  one-hot digit enable, [0]=digit 1, [1]=digit 2, active-high
//  FrameDone out  1  high during last cycle of each frame
//  Dim       in   1  only when SEG_SCAN_DIM_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=BLANK1, slot counter=0, Segments=0, DigitEn=2'b00, FrameDone=0,
//    shadow Dig1/Dig2=0, pending buffer=0, pending flag=0. Reset mid-frame aborts immediately.
//  - FSM BLANK1 -> SHOW1 -> BLANK2 -> SHOW2 -> BLANK1. BLANKx lasts BLANK_CYCLES clocks
//    (skipped when 0); SHOWx lasts DWELL_CYCLES. Frame = 2*(BLANK_CYCLES+DWELL_CYCLES) clocks.
//  - Outputs are registered; no combinational path from inputs to outputs.
//    BLANKx: Segments=0, DigitEn=00. SHOW1: Segments=shadow1, DigitEn=01.
//    SHOW2: Segments=shadow2, DigitEn=10. DigitEn never has both bits set.
//  - FrameDone=1 exactly during last SHOW2 cycle; 0 otherwise.
//  - Load=1: pending <= {Dig1,Dig2}, pending flag <= 1. Multiple Loads per frame: last wins.
//  - Frame boundary (clock edge ending the FrameDone cycle): if pending flag, shadow <= pending,
//    flag <= 0. Load on the FrameDone cycle bypasses: shadow <= that cycle's Dig1/Dig2 directly,
//    flag left 0.
//  - Slot counter width = $clog2(max(DWELL_CYCLES,BLANK_CYCLES)); wraps to 0 on every state change.
// CONFIGURATION
//  SEG_SCAN_DIM_EN defined: Dim port exists; sampled at frame boundary. When sampled 1, each
//   SHOWx drives pattern/enable only for first ceil(DWELL_CYCLES/2) cycles, then Segments=0,
//   DigitEn=00 for rest of slot (state timing unchanged). Sampled 0: full dwell.
//  Not defined: no Dim port; every SHOWx lit for full DWELL_CYCLES.
// TESTING  (bench params DWELL_CYCLES=4, BLANK_CYCLES=1; frame = 10 clocks)
//  1 Reset held 3 clocks, released -> Segments=00, DigitEn=00, FrameDone=0; DigitEn=01 first on
//    clock 2 after release, pattern 00 (shadow empty).
//  2 Load Dig1=8'b00111001, Dig2=8'b01111101 mid-frame -> unchanged until boundary; next frame:
//    1 clk DigitEn=00, 4 clks Segments=00111001/DigitEn=01, 1 clk blank, 4 clks 01111101/10,
//    FrameDone on 10th.
//  3 Load 0x06 then 0x5B same frame -> next frame shows 0x5B pattern set (last wins).
//  4 Load 0x3F/0x06 on FrameDone cycle -> very next SHOW1 shows 0x3F (bypass).
//  5 Reset asserted during SHOW2 -> next cycle all outputs 0, shadow 0, state BLANK1.
//  6 SEG_SCAN_DIM_EN, Dim=1 before boundary -> SHOW1 lit 2 clks then 2 clks dark; FrameDone period
//    still 10; over 1000 clocks DigitEn never 2'b11.

Source files
------------

// File: rtl/seven_seg_scan_mux.sv
// Two-digit common-segment scan mux; registered outputs, 1-clock latency; no backpressure (load is a strobe).
// Optional SEG_SCAN_DIM_EN macro adds a dim input that halves each digit's lit time per frame.
module seven_seg_scan_mux #(
  parameter int DWELL_CYCLES = 4000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dig1,
  input  logic [7:0] dig2,
  input  logic       load,
`ifdef SEG_SCAN_DIM_EN
  input  logic       dim,
`endif
  output logic [7:0] segments,
  output logic [1:0] digit_en,
  output logic       frame_done
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DLAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0] HALF  = CW'((DWELL_CYCLES + 1) / 2);

  typedef enum logic [1:0] {BLANK1, SHOW1, BLANK2, SHOW2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic [15:0]   pending, pending_nxt;
  logic          pflag, pflag_nxt;
  logic          dim_q, dim_nxt;
  logic          boundary, dark;
  logic [7:0]    seg_nxt;
  logic [1:0]    en_nxt;
  logic          fd_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      BLANK1: if (BLANK_CYCLES == 0 || cnt == BLAST) begin
        state_nxt = SHOW1;
        cnt_nxt   = '0;
      end
      SHOW1: if (cnt == DLAST) begin
        state_nxt = (BLANK_CYCLES == 0) ? SHOW2 : BLANK2;
        cnt_nxt   = '0;
      end
      BLANK2: if (BLANK_CYCLES == 0 || cnt == BLAST) begin
        state_nxt = SHOW2;
        cnt_nxt   = '0;
      end
      SHOW2: if (cnt == DLAST) begin
        state_nxt = (BLANK_CYCLES == 0) ? SHOW1 : BLANK1;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = BLANK1;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Shadow only moves on the frame edge; a load on that same edge goes straight to the shadow.
  always_comb begin
    boundary    = (state == SHOW2) && (cnt == DLAST);
    shadow_nxt  = shadow;
    pending_nxt = pending;
    pflag_nxt   = pflag;
    dim_nxt     = dim_q;
    if (load) pending_nxt = {dig1, dig2};
    if (boundary) begin
      if (load)       shadow_nxt = {dig1, dig2};
      else if (pflag) shadow_nxt = pending;
      pflag_nxt = 1'b0;
`ifdef SEG_SCAN_DIM_EN
      dim_nxt = dim;
`endif
    end else if (load) begin
      pflag_nxt = 1'b1;
    end
  end

  always_comb begin
    dark    = dim_nxt && (cnt_nxt >= HALF);
    seg_nxt = '0;
    en_nxt  = 2'b00;
    if (state_nxt == SHOW1 && !dark) begin
      seg_nxt = shadow_nxt[15:8];
      en_nxt  = 2'b01;
    end else if (state_nxt == SHOW2 && !dark) begin
      seg_nxt = shadow_nxt[7:0];
      en_nxt  = 2'b10;
    end
    fd_nxt = (state_nxt == SHOW2) && (cnt_nxt == DLAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK1;
      cnt        <= '0;
      shadow     <= '0;
      pending    <= '0;
      pflag      <= 1'b0;
      dim_q      <= 1'b0;
      segments   <= '0;
      digit_en   <= 2'b00;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      pflag      <= pflag_nxt;
      dim_q      <= dim_nxt;
      segments   <= seg_nxt;
      digit_en   <= en_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule
